// File: rtl/unpack.sv
// FP16 unpack stage: splits a raw half-precision word into sign, unbiased exponent
// and hidden-bit mantissa with special-value flags; subnormals are normalized one shift per cycle.
module unpack (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        u_valid,
    input  logic        u_ready,
    output logic        sign_out,
    output logic [6:0]  exp_out,
    output logic [10:0] mant_out,
    output logic        is_nan_out,
    output logic        is_pinf_out,
    output logic        is_ninf_out,
    output logic        is_zero_out
);

    localparam int unsigned FRAC_W = 10;
    localparam int unsigned BEXP_W = 5;
    localparam int unsigned EXP_W  = 7;
    localparam int unsigned MANT_W = FRAC_W + 1;
    localparam int unsigned BIAS   = 15;

    localparam logic [BEXP_W-1:0] BEXP_MAX = '1;
    localparam logic [EXP_W-1:0]  EXP_SUBN = EXP_W'(1) - EXP_W'(BIAS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_NORM,
        ST_OUT
    } state_e;

    state_e              state_q, state_d;
    logic                sign_q, sign_d;
    logic [EXP_W-1:0]    exp_q, exp_d;
    logic [MANT_W-1:0]   mant_q, mant_d;
    logic                nan_q, nan_d;
    logic                pinf_q, pinf_d;
    logic                ninf_q, ninf_d;
    logic                zero_q, zero_d;

    logic [BEXP_W-1:0]   in_exp;
    logic [FRAC_W-1:0]   in_frac;
    logic                in_sign;
    logic                accept;

    logic [EXP_W-1:0]    ld_exp;
    logic [MANT_W-1:0]   ld_mant;
    logic                ld_nan, ld_pinf, ld_ninf, ld_zero;
    logic                ld_subn;

    assign in_sign = in_data[15];
    assign in_exp  = in_data[14:10];
    assign in_frac = in_data[9:0];

    // Handshake: reset has priority over enable; a result may drain while a new word enters.
    assign in_ready = enable & ~rst
                    & ((state_q == ST_IDLE) | ((state_q == ST_OUT) & u_ready));
    assign u_valid  = enable & ~rst & (state_q == ST_OUT);
    assign accept   = in_valid & in_ready;

    // Classification of the incoming word, used only on accept.
    always_comb begin
        ld_exp  = '0;
        ld_mant = '0;
        ld_nan  = 1'b0;
        ld_pinf = 1'b0;
        ld_ninf = 1'b0;
        ld_zero = 1'b0;
        ld_subn = 1'b0;
        if (in_exp == BEXP_MAX) begin
            if (in_frac != '0) begin
                ld_nan = 1'b1;
            end else begin
                ld_pinf = ~in_sign;
                ld_ninf = in_sign;
            end
        end else if (in_exp == '0) begin
            if (in_frac == '0) begin
                ld_zero = 1'b1;
            end else begin
                ld_subn = 1'b1;
                ld_exp  = EXP_SUBN;
                ld_mant = {1'b0, in_frac};
            end
        end else begin
            ld_exp  = EXP_W'(in_exp) - EXP_W'(BIAS);
            ld_mant = {1'b1, in_frac};
        end
    end

    // Next-state and register-update logic; enable=0 leaves everything as is.
    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        mant_d  = mant_q;
        nan_d   = nan_q;
        pinf_d  = pinf_q;
        ninf_d  = ninf_q;
        zero_d  = zero_q;

        if (enable) begin
            unique case (state_q)
                ST_IDLE, ST_OUT: begin
                    if (accept) begin
                        state_d = ld_subn ? ST_NORM : ST_OUT;
                        sign_d  = in_sign;
                        exp_d   = ld_exp;
                        mant_d  = ld_mant;
                        nan_d   = ld_nan;
                        pinf_d  = ld_pinf;
                        ninf_d  = ld_ninf;
                        zero_d  = ld_zero;
                    end else if ((state_q == ST_OUT) && u_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_NORM: begin
                    // Hidden bit reaches position 10 after this shift when bit 9 is set now.
                    mant_d = {mant_q[MANT_W-2:0], 1'b0};
                    exp_d  = exp_q - EXP_W'(1);
                    if (mant_q[MANT_W-2]) begin
                        state_d = ST_OUT;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            mant_q  <= '0;
            nan_q   <= 1'b0;
            pinf_q  <= 1'b0;
            ninf_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            mant_q  <= mant_d;
            nan_q   <= nan_d;
            pinf_q  <= pinf_d;
            ninf_q  <= ninf_d;
            zero_q  <= zero_d;
        end
    end

    assign sign_out    = sign_q;
    assign exp_out     = exp_q;
    assign mant_out    = mant_q;
    assign is_nan_out  = nan_q;
    assign is_pinf_out = pinf_q;
    assign is_ninf_out = ninf_q;
    assign is_zero_out = zero_q;

endmodule
